// File: rtl/pcs_tx_serializer_pkg.sv
// Shared PCS transmit constants and the registered line-output bundle.
// Used by the serializer and the 8b/10b encoder.
package pcs_tx_serializer_pkg;

    localparam int PCS_SYM_W = 10;

    // K28.5 comma in both running-disparity flavours
    localparam logic [PCS_SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [PCS_SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef struct packed {
        logic ser;
        logic strobe;
        logic idle;
    } line_t;

endpackage

// File: rtl/pcs_sym_fifo.sv
// Synchronous code-group FIFO with level, full and empty.
// The head is read combinationally, so a same-cycle push never leaks into a pop.
module pcs_sym_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pcs_tx_serializer.sv
// Serialises queued 10-bit code-groups onto the line, one bit per clk,
// filling with IDLE_SYM whenever nothing is queued.
module pcs_tx_serializer
    import pcs_tx_serializer_pkg::*;
#(
    parameter int               SYM_W      = PCS_SYM_W,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [SYM_W-1:0] IDLE_SYM   = K28_5_RDN,
    parameter bit               MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SYM_W-1:0]              sym_in,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    output logic                          ser_out,
    output logic                          sym_strobe,
    output logic                          idle_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int             CW   = $clog2(SYM_W);
    localparam logic [CW-1:0]  LAST = CW'(SYM_W - 1);

    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    tx_idx;
    logic [SYM_W-1:0] shreg;
    logic [SYM_W-1:0] head;
    logic [SYM_W-1:0] next_sym;
    logic             load;
    logic             pop_now;
    logic             push;
    logic             empty;
    logic             full;
    logic             first_bit;
    line_t            line_q;
    line_t            line_d;

    assign load      = bit_cnt == '0;
    assign pop_now   = load & ~empty;
    assign sym_ready = ~full | pop_now;
    assign push      = sym_valid & sym_ready;

    pcs_sym_fifo #(
        .W     (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .data  (sym_in),
        .pop   (pop_now),
        .head  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    // tx_idx maps the bit counter onto the shift register in line order
    always_comb begin
        next_sym      = empty ? IDLE_SYM : head;
        first_bit     = MSB_FIRST ? next_sym[SYM_W-1] : next_sym[0];
        tx_idx        = MSB_FIRST ? LAST - bit_cnt : bit_cnt;
        line_d.ser    = load ? first_bit : shreg[tx_idx];
        line_d.strobe = load;
        line_d.idle   = load ? empty : line_q.idle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            line_q   <= '0;
            overflow <= 1'b0;
        end else begin
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
            if (load) begin
                shreg <= next_sym;
            end
            line_q <= line_d;
            if (sym_valid & ~sym_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ser_out     = line_q.ser;
    assign sym_strobe  = line_q.strobe;
    assign idle_active = line_q.idle;

endmodule

// File: tb/tb_pcs_tx_serializer.sv
// Scoreboard bench for pcs_tx_serializer: stimulus queues accepted code-groups,
// a line monitor rebuilds each code-group from ser_out and checks it.
module tb_pcs_tx_serializer;

    localparam logic [9:0] IDLE = 10'b0011111010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sym_in = '0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic       ser_out;
    logic       sym_strobe;
    logic       idle_active;
    logic [2:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int idle_cnt = 0;
    int data_cnt = 0;
    int d0 = 0;
    int i0 = 0;

    logic [9:0] exp_q [$];

    logic [9:0] t3_syms [6] = '{10'b0101010101, 10'b1100110011, 10'b1110001110,
                                10'b0001111000, 10'b1111100000, 10'b0000011111};
    logic [9:0] t4_syms [5] = '{10'b1000000001, 10'b0100000010, 10'b0010000100,
                                10'b0001001000, 10'b0000110000};
    logic [9:0] t5_syms [8] = '{10'b1101001011, 10'b0110110100, 10'b1010011100,
                                10'b0011100011, 10'b1001010110, 10'b0111000101,
                                10'b1100011010, 10'b0100101101};

    pcs_tx_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .sym_in      (sym_in),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .ser_out     (ser_out),
        .sym_strobe  (sym_strobe),
        .idle_active (idle_active),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line monitor: rebuild each code-group from the strobe onwards
    int         nb = 0;
    int         gap = 0;
    bit         active = 1'b0;
    bit         cur_idle = 1'b0;
    logic [9:0] word = '0;

    always @(negedge clk) begin
        if (rst) begin
            nb = 0;
            gap = 0;
            active = 1'b0;
        end else begin
            if (sym_strobe) begin
                if (active) chk("strobe_gap", 32'(gap), 10);
                active = 1'b1;
                gap = 0;
                nb = 0;
                cur_idle = idle_active;
                word = '0;
            end else if (active && gap >= 10) begin
                chk("strobe_missing", 32'(sym_strobe), 1);
                active = 1'b0;
            end
            if (active) begin
                chk("idle_flag_stable", 32'(idle_active), 32'(cur_idle));
                word = {word[8:0], ser_out};
                nb++;
                gap++;
                if (nb == 10) begin
                    if (cur_idle) begin
                        chk("idle_sym", 32'(word), 32'(IDLE));
                        idle_cnt++;
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_data: got %0h expected none at %0t", word, $time);
                        data_cnt++;
                    end else begin
                        chk("data_sym", 32'(word), 32'(exp_q.pop_front()));
                        data_cnt++;
                    end
                end
            end
        end
    end

    task automatic push(logic [9:0] v, bit exp_ready);
        sym_in = v;
        sym_valid = 1'b1;
        #1;
        chk("sym_ready", 32'(sym_ready), 32'(exp_ready));
        if (exp_ready) exp_q.push_back(v);
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_strobe && n < 30);
        chk("strobe_timeout", 32'(sym_strobe), 1);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_ser_out", 32'(ser_out), 0);
        chk("rst_strobe", 32'(sym_strobe), 0);
        chk("rst_idle", 32'(idle_active), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(sym_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_strobe", 32'(sym_strobe), 1);
        chk("rel_idle", 32'(idle_active), 1);
        chk("rel_first_bit", 32'(ser_out), 0);
        chk("rel_level", 32'(fifo_level), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle fill
        @(negedge clk);
        assert_reset();
        repeat (40) @(negedge clk);
        chk("t1_idle_count", 32'(idle_cnt), 4);
        chk("t1_data_count", 32'(data_cnt), 0);
        chk("t1_idle_active", 32'(idle_active), 1);
        chk("t1_level", 32'(fifo_level), 0);

        // Single symbol while idle
        wait_strobe();
        d0 = data_cnt;
        i0 = idle_cnt;
        push(10'b1011100100, 1'b1);
        chk("t2_level_queued", 32'(fifo_level), 1);
        repeat (9) @(negedge clk);
        chk("t2_strobe", 32'(sym_strobe), 1);
        chk("t2_idle_active", 32'(idle_active), 0);
        chk("t2_first_bit", 32'(ser_out), 1);
        chk("t2_level_popped", 32'(fifo_level), 0);
        repeat (20) @(negedge clk);
        chk("t2_data_count", 32'(data_cnt - d0), 1);
        chk("t2_idle_after", 32'(idle_cnt - i0), 2);
        chk("t2_fill_active", 32'(idle_active), 1);

        // Burst of 6: 4 accepted, 2 dropped
        wait_strobe();
        for (int i = 0; i < 6; i++) push(t3_syms[i], i < 4);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_level", 32'(fifo_level), 4);
        chk("t3_ready_full", 32'(sym_ready), 0);
        wait_drain(100);
        chk("t3_overflow_sticky", 32'(overflow), 1);
        assert_reset();

        // Full FIFO, push on a load edge
        wait_strobe();
        for (int i = 0; i < 4; i++) push(t4_syms[i], 1'b1);
        repeat (4) @(negedge clk);
        chk("t4_ready_full", 32'(sym_ready), 0);
        chk("t4_level_full", 32'(fifo_level), 4);
        @(negedge clk);
        push(t4_syms[4], 1'b1);
        chk("t4_level_kept", 32'(fifo_level), 4);
        chk("t4_no_overflow", 32'(overflow), 0);
        wait_drain(150);

        // Sustained rate: one push per code-group period
        wait_strobe();
        d0 = data_cnt;
        i0 = idle_cnt;
        for (int i = 0; i < 8; i++) begin
            push(t5_syms[i], 1'b1);
            chk("t5_level", 32'(fifo_level), 1);
            repeat (9) @(negedge clk);
        end
        wait_drain(50);
        chk("t5_data_count", 32'(data_cnt - d0), 8);
        chk("t5_idle_count", 32'(idle_cnt - i0), 1);
        chk("t5_no_overflow", 32'(overflow), 0);

        // Reset mid-symbol with three queued
        wait_strobe();
        for (int i = 0; i < 3; i++) push(t3_syms[i], 1'b1);
        @(negedge clk);
        chk("t6_level_queued", 32'(fifo_level), 3);
        d0 = data_cnt;
        assert_reset();
        repeat (40) @(negedge clk);
        chk("t6_no_data", 32'(data_cnt - d0), 0);
        chk("t6_level", 32'(fifo_level), 0);

        chk("end_queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
